sii_l2t_req_tracker: RTL and testbench
======================================

# sii_l2t_req_tracker

Parametrised inbound request tracker between the SII and the L2 tag banks, running on `iol2clk`. For every bank it tracks outstanding inbound-queue entries from request-valid/dequeue pairs and parses header and payload beats with a per-bank state machine. It flags sticky protocol, overflow and underflow errors, and can keep optional per-bank request statistics. It generalises the per-bank valid monitors to N banks with credit accounting and packet-framing checks, and is synthesisable for on-chip debug as well as usable in the bench.

## Interface
Parameters:
- `NUM_BANKS`, 8: number of L2T banks tracked.
- `REQ_W`, 32: width of each bank's request bus.
- `IQ_DEPTH`, 16: inbound-queue entries per bank; must be at least 2.
- `WR_BIT`, 27: header bit index; 1 means the request carries a payload.
- `PAYLOAD_BEATS`, 4: payload beats following a write header; must be at least 1.
- `STAT_W`, 16: width of each statistics counter.

Ports (clock and reset first):
- `iol2clk`, in, 1: sole clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `sii_l2t_req`, in, NUM_BANKS*REQ_W: request buses; bank b occupies bits [b*REQ_W +: REQ_W].
- `sii_l2t_req_vld`, in, NUM_BANKS: header-beat valid, one bit per bank.
- `l2t_sii_iq_dequeue`, in, NUM_BANKS: one-cycle pulse per freed queue entry.
- `enable`, in, 1: gates error capture and statistics.
- `clr_err`, in, 1: synchronous clear of all sticky error flags.
- `iq_cnt`, out, NUM_BANKS*$clog2(IQ_DEPTH+1): outstanding entries per bank.
- `ovf_err`, out, NUM_BANKS: sticky overflow flag per bank.
- `unf_err`, out, NUM_BANKS: sticky underflow flag per bank.
- `proto_err`, out, NUM_BANKS: sticky framing-error flag per bank.
- `err_any`, out, 1: registered OR of all sticky flags.
- `req_stat`, out, NUM_BANKS*STAT_W: request counts; present only under the macro below.

## Operation
- Reset values: all `iq_cnt` = 0, all error flags = 0, `err_any` = 0, `req_stat` = 0, every bank FSM in IDLE.
- Credit accounting runs regardless of `enable`.
  - inc = `req_vld[b]` while the bank FSM is in IDLE; dec = `dequeue[b]`.
  - inc and dec together: count unchanged.
  - inc alone with count = IQ_DEPTH: count holds at IQ_DEPTH; `ovf_err[b]` is set if `enable`.
  - dec alone with count = 0: count holds at 0; `unf_err[b]` is set if `enable`.
- Per-bank FSM, states IDLE and DATA, with a beat counter of width $clog2(PAYLOAD_BEATS):
  - IDLE, `req_vld` asserted and `req[WR_BIT]` = 1: go to DATA with beat counter = PAYLOAD_BEATS-1.
  - IDLE, `req_vld` asserted and `req[WR_BIT]` = 0: stay in IDLE; this is a read.
  - DATA: decrement the counter every cycle; return to IDLE on the cycle the counter is 0.
  - DATA, `req_vld` asserted: `proto_err[b]` is set if `enable`. The beat is not counted as a request and the counter keeps running.
- Sticky flags:
  - Set has priority over `clr_err` in the same cycle.
  - Flags are never cleared by `enable` deassertion.
- `err_any` follows the flag registers by one cycle.

## Timing
- All outputs are registered; nothing is combinational from inputs.
- `iq_cnt` and the flags reflect inputs sampled at edge N on the outputs after edge N.
- `err_any` reflects them one edge later (N+1).
- Minimum header-to-header spacing:
  - write: PAYLOAD_BEATS+1 cycles;
  - read: 1 cycle (back-to-back allowed).
- Reset asserted mid-packet: FSM returns to IDLE and counters clear immediately (asynchronous). The first cycle after reset release is treated as IDLE.
- Banks are fully independent; simultaneous events on all banks are legal.

## Configuration
- Macro `SII_L2T_TRACKER_STATS_EN`.
- Defined:
  - `req_stat[b]` increments on each accepted header (IDLE and `req_vld`) while `enable` is high.
  - Counters saturate at 2^STAT_W-1 and are cleared only by `rst`.
- Undefined:
  - The `req_stat` port is absent and no counter flops are built.
  - All other behaviour is identical.

## Structure
- Shared package `sii_l2t_pkg`:
  - FSM state enum (IDLE, DATA);
  - default parameter constants;
  - a `cnt_w` function returning $clog2(IQ_DEPTH+1).
- One sub-module, `sii_l2t_bank_trk`:
  - covers a single bank's credit counter, FSM, flags and optional stat counter;
  - instantiated NUM_BANKS times in a generate loop;
  - the top level holds only the bus slicing and the `err_any` reduction.

## Test plan
- Bank 3: 16 read headers on consecutive cycles, then one more with no dequeue → `iq_cnt[3]` = 16, `ovf_err[3]` = 1, `err_any` = 1 one cycle later, other banks 0.
- Bank 0: `req_vld` and `dequeue` together at count 5 → count stays 5; a lone dequeue at count 0 → `unf_err[0]` = 1, count stays 0.
- Bank 5: write header (bit 27 = 1), then `req_vld` on payload beat 2 → `proto_err[5]` = 1, `iq_cnt[5]` = 1. The next header after 4 beats is accepted → count 2.
- All 8 banks: one write each on the same cycle → each `iq_cnt` = 1, no errors; all FSMs back in IDLE after exactly 4 cycles.
- With `enable` = 0, force an overflow on bank 1 → no flag set, count saturates at 16. Then `clr_err` asserted in the same cycle as a new overflow with `enable` = 1 → flag remains 1.
- Under the macro, with STAT_W = 4: 20 read headers on bank 2 → `req_stat[2]` = 15. Assert `rst` mid-write → all outputs return to 0 asynchronously.

Source files
------------

// File: rtl/sii_l2t_pkg.sv
// Shared definitions for the SII -> L2T inbound request tracker.
//
// Contents:
//   trk_state_e   per-bank framing state (IDLE waits for a header,
//                 DATA walks the payload beats of a write)
//   DEF_*         default parameter values used by the tracker modules
//   cnt_w()       width of an outstanding-entry counter that can hold
//                 0..IQ_DEPTH inclusive
//   beat_w()      width of the payload beat counter, never below 1 bit
package sii_l2t_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } trk_state_e;

  localparam int DEF_NUM_BANKS     = 8;
  localparam int DEF_REQ_W         = 32;
  localparam int DEF_IQ_DEPTH      = 16;
  localparam int DEF_WR_BIT        = 27;
  localparam int DEF_PAYLOAD_BEATS = 4;
  localparam int DEF_STAT_W        = 16;

  function automatic int cnt_w(input int iq_depth);
    return $clog2(iq_depth + 1);
  endfunction

  // A single payload beat would give $clog2(1) = 0; keep one bit so the
  // counter stays a legal vector.
  function automatic int beat_w(input int payload_beats);
    return (payload_beats > 1) ? $clog2(payload_beats) : 1;
  endfunction

endpackage

// File: rtl/sii_l2t_bank_trk.sv
// Single-bank tracker: outstanding-entry credit counter, header/payload
// framing FSM, sticky error flags and (optionally) a saturating request
// counter.
//
// Optional feature macro: SII_L2T_TRACKER_STATS_EN (adds req_stat).
//
// Ports:
//   iol2clk    clock
//   rst        asynchronous active-high reset
//   req_vld    header-beat valid for this bank
//   req_wr     write bit of the header on the request bus
//   dequeue    one-cycle pulse per freed inbound-queue entry
//   enable     gates error capture and statistics
//   clr_err    synchronous clear of the sticky flags (set wins)
//   iq_cnt     outstanding entries, 0..IQ_DEPTH
//   ovf_err    sticky overflow flag
//   unf_err    sticky underflow flag
//   proto_err  sticky framing flag (header valid during payload)
//   req_stat   accepted-header count, saturating (macro only)
module sii_l2t_bank_trk
  import sii_l2t_pkg::*;
#(
  parameter int IQ_DEPTH      = DEF_IQ_DEPTH,
  parameter int PAYLOAD_BEATS = DEF_PAYLOAD_BEATS,
  parameter int STAT_W        = DEF_STAT_W
) (
  input  logic                       iol2clk,
  input  logic                       rst,
  input  logic                       req_vld,
  input  logic                       req_wr,
  input  logic                       dequeue,
  input  logic                       enable,
  input  logic                       clr_err,
  output logic [cnt_w(IQ_DEPTH)-1:0] iq_cnt,
  output logic                       ovf_err,
  output logic                       unf_err,
  output logic                       proto_err
`ifdef SII_L2T_TRACKER_STATS_EN
  ,
  output logic [STAT_W-1:0]          req_stat
`endif
);

  localparam int CW = cnt_w(IQ_DEPTH);
  localparam int BW = beat_w(PAYLOAD_BEATS);
  localparam logic [CW-1:0] DEPTH_C   = CW'(IQ_DEPTH);
  localparam logic [BW-1:0] LAST_BEAT = BW'(PAYLOAD_BEATS - 1);

  trk_state_e    state_reg, state_next;
  logic [BW-1:0] beat_reg,  beat_next;
  logic [CW-1:0] cnt_reg,   cnt_next;
  logic          ovf_reg,   ovf_next;
  logic          unf_reg,   unf_next;
  logic          proto_reg, proto_next;

  logic is_idle;
  logic inc;
  logic dec;
  logic hit_ovf;
  logic hit_unf;
  logic hit_proto;

  // Event decode. A header is only a request while the bank is idle; a
  // valid seen during payload is a framing fault and takes no credit.
  always_comb begin
    is_idle   = (state_reg == ST_IDLE);
    inc       = req_vld & is_idle;
    dec       = dequeue;
    hit_ovf   = inc & ~dec & (cnt_reg == DEPTH_C);
    hit_unf   = dec & ~inc & (cnt_reg == '0);
    hit_proto = req_vld & ~is_idle;
  end

  // Credit counter: simultaneous inc/dec cancel, both ends saturate.
  always_comb begin
    cnt_next = cnt_reg;
    if (inc && !dec && (cnt_reg != DEPTH_C)) begin
      cnt_next = cnt_reg + CW'(1);
    end else if (dec && !inc && (cnt_reg != '0)) begin
      cnt_next = cnt_reg - CW'(1);
    end
  end

  // Framing FSM. The beat counter is loaded with PAYLOAD_BEATS-1 and the
  // bank leaves DATA on the cycle it reads zero, so a write occupies
  // exactly PAYLOAD_BEATS cycles after its header. It keeps running even
  // when a stray header arrives mid-payload.
  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req_vld && req_wr) begin
          state_next = ST_DATA;
          beat_next  = LAST_BEAT;
        end
      end
      ST_DATA: begin
        if (beat_reg == '0) begin
          state_next = ST_IDLE;
        end else begin
          beat_next = beat_reg - BW'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        beat_next  = '0;
      end
    endcase
  end

  // Sticky flags: a qualifying set beats a clear in the same cycle.
  always_comb begin
    ovf_next   = ovf_reg;
    unf_next   = unf_reg;
    proto_next = proto_reg;
    if (enable && hit_ovf)        ovf_next = 1'b1;
    else if (clr_err)             ovf_next = 1'b0;
    if (enable && hit_unf)        unf_next = 1'b1;
    else if (clr_err)             unf_next = 1'b0;
    if (enable && hit_proto)      proto_next = 1'b1;
    else if (clr_err)             proto_next = 1'b0;
  end

  always_ff @(posedge iol2clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      beat_reg  <= '0;
      cnt_reg   <= '0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
      proto_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
      cnt_reg   <= cnt_next;
      ovf_reg   <= ovf_next;
      unf_reg   <= unf_next;
      proto_reg <= proto_next;
    end
  end

  assign iq_cnt    = cnt_reg;
  assign ovf_err   = ovf_reg;
  assign unf_err   = unf_reg;
  assign proto_err = proto_reg;

`ifdef SII_L2T_TRACKER_STATS_EN
  logic [STAT_W-1:0] stat_reg, stat_next;

  // Counts every accepted header (overflowing ones included); holds at
  // all-ones and is only cleared by reset.
  always_comb begin
    stat_next = stat_reg;
    if (enable && inc && (stat_reg != '1)) begin
      stat_next = stat_reg + STAT_W'(1);
    end
  end

  always_ff @(posedge iol2clk or posedge rst) begin
    if (rst) begin
      stat_reg <= '0;
    end else begin
      stat_reg <= stat_next;
    end
  end

  assign req_stat = stat_reg;
`endif

endmodule

// File: rtl/sii_l2t_req_tracker.sv
// Inbound request tracker between SII and the L2 tag banks. Slices the
// per-bank buses, instantiates one sii_l2t_bank_trk per bank and
// registers the OR of every sticky flag.
//
// Optional feature macro: SII_L2T_TRACKER_STATS_EN (adds req_stat).
//
// Ports:
//   iol2clk             clock
//   rst                 asynchronous active-high reset
//   sii_l2t_req         request buses, bank b at [b*REQ_W +: REQ_W]
//   sii_l2t_req_vld     header-beat valid per bank
//   l2t_sii_iq_dequeue  queue-entry free pulse per bank
//   enable              gates error capture and statistics
//   clr_err             synchronous clear of all sticky flags
//   iq_cnt              outstanding entries, cnt_w(IQ_DEPTH) bits per bank
//   ovf_err/unf_err/proto_err  sticky flags per bank
//   err_any             registered OR of all sticky flags (one edge later)
//   req_stat            per-bank accepted-header counts (macro only)
module sii_l2t_req_tracker
  import sii_l2t_pkg::*;
#(
  parameter int NUM_BANKS     = DEF_NUM_BANKS,
  parameter int REQ_W         = DEF_REQ_W,
  parameter int IQ_DEPTH      = DEF_IQ_DEPTH,
  parameter int WR_BIT        = DEF_WR_BIT,
  parameter int PAYLOAD_BEATS = DEF_PAYLOAD_BEATS,
  parameter int STAT_W        = DEF_STAT_W
) (
  input  logic                                 iol2clk,
  input  logic                                 rst,
  input  logic [NUM_BANKS*REQ_W-1:0]           sii_l2t_req,
  input  logic [NUM_BANKS-1:0]                 sii_l2t_req_vld,
  input  logic [NUM_BANKS-1:0]                 l2t_sii_iq_dequeue,
  input  logic                                 enable,
  input  logic                                 clr_err,
  output logic [NUM_BANKS*cnt_w(IQ_DEPTH)-1:0] iq_cnt,
  output logic [NUM_BANKS-1:0]                 ovf_err,
  output logic [NUM_BANKS-1:0]                 unf_err,
  output logic [NUM_BANKS-1:0]                 proto_err,
  output logic                                 err_any
`ifdef SII_L2T_TRACKER_STATS_EN
  ,
  output logic [NUM_BANKS*STAT_W-1:0]          req_stat
`endif
);

  localparam int CW = cnt_w(IQ_DEPTH);

  logic err_any_reg;

  // Only the write bit of each header steers the tracker; the remaining
  // request bits are folded here so every input bit has a sink.
  logic req_unused;
  assign req_unused = ^sii_l2t_req;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      sii_l2t_bank_trk #(
        .IQ_DEPTH      (IQ_DEPTH),
        .PAYLOAD_BEATS (PAYLOAD_BEATS),
        .STAT_W        (STAT_W)
      ) u_trk (
        .iol2clk   (iol2clk),
        .rst       (rst),
        .req_vld   (sii_l2t_req_vld[gi]),
        .req_wr    (sii_l2t_req[gi*REQ_W + WR_BIT]),
        .dequeue   (l2t_sii_iq_dequeue[gi]),
        .enable    (enable),
        .clr_err   (clr_err),
        .iq_cnt    (iq_cnt[gi*CW +: CW]),
        .ovf_err   (ovf_err[gi]),
        .unf_err   (unf_err[gi]),
        .proto_err (proto_err[gi])
`ifdef SII_L2T_TRACKER_STATS_EN
        ,
        .req_stat  (req_stat[gi*STAT_W +: STAT_W])
`endif
      );
    end
  endgenerate

  // Built from the flag registers, so it trails them by one edge.
  always_ff @(posedge iol2clk or posedge rst) begin
    if (rst) begin
      err_any_reg <= 1'b0;
    end else begin
      err_any_reg <= |{ovf_err, unf_err, proto_err};
    end
  end

  assign err_any = err_any_reg;

endmodule

// File: tb/tb_sii_l2t_req_tracker.sv
// Bench for sii_l2t_req_tracker: directed scenarios followed by random
// traffic, all compared every cycle against a per-bank reference model
// (outstanding count, remaining payload cycles, flags, stats).
module tb_sii_l2t_req_tracker;

  localparam int NB    = 8;
  localparam int RW    = 32;
  localparam int DEPTH = 16;
  localparam int WRB   = 27;
  localparam int PB    = 4;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef SII_L2T_TRACKER_STATS_EN
  localparam int SW    = 4;
`else
  localparam int SW    = 16;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NB*RW-1:0]  req;
  logic [NB-1:0]     vld, deq, wr;
  logic              en, clr;
  logic [NB*CW-1:0]  iq_cnt;
  logic [NB-1:0]     ovf_err, unf_err, proto_err;
  logic              err_any;
`ifdef SII_L2T_TRACKER_STATS_EN
  logic [NB*SW-1:0]  req_stat;
`endif

  always #5 clk = ~clk;

  sii_l2t_req_tracker #(
    .NUM_BANKS(NB), .REQ_W(RW), .IQ_DEPTH(DEPTH), .WR_BIT(WRB),
    .PAYLOAD_BEATS(PB), .STAT_W(SW)
  ) dut (
    .iol2clk            (clk),
    .rst                (rst),
    .sii_l2t_req        (req),
    .sii_l2t_req_vld    (vld),
    .l2t_sii_iq_dequeue (deq),
    .enable             (en),
    .clr_err            (clr),
    .iq_cnt             (iq_cnt),
    .ovf_err            (ovf_err),
    .unf_err            (unf_err),
    .proto_err          (proto_err),
    .err_any            (err_any)
`ifdef SII_L2T_TRACKER_STATS_EN
    ,
    .req_stat           (req_stat)
`endif
  );

  // Reference model: busy = payload cycles still to come (0 = idle).
  int m_cnt  [NB];
  int m_busy [NB];
  int m_stat [NB];
  bit m_ovf  [NB];
  bit m_unf  [NB];
  bit m_proto[NB];
  bit m_any;

  int checks   = 0;
  int failures = 0;
  int step_no  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d (step %0d)", tag, obs, exp, step_no);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      m_cnt[b] = 0; m_busy[b] = 0; m_stat[b] = 0;
      m_ovf[b] = 0; m_unf[b] = 0; m_proto[b] = 0;
    end
    m_any = 0;
  endtask

  // Applies one clock edge's worth of the rules to the model.
  task automatic model_update();
    bit any_prev;
    any_prev = 0;
    for (int b = 0; b < NB; b++) any_prev |= m_ovf[b] | m_unf[b] | m_proto[b];
    for (int b = 0; b < NB; b++) begin
      bit idle, inc, dec, s_ovf, s_unf, s_proto;
      idle    = (m_busy[b] == 0);
      inc     = vld[b] && idle;
      dec     = deq[b];
      s_ovf   = 0;
      s_unf   = 0;
      s_proto = en && vld[b] && !idle;
      if (inc && !dec) begin
        if (m_cnt[b] == DEPTH) s_ovf = en;
        else m_cnt[b]++;
      end else if (dec && !inc) begin
        if (m_cnt[b] == 0) s_unf = en;
        else m_cnt[b]--;
      end
      m_ovf[b]   = s_ovf   ? 1'b1 : (clr ? 1'b0 : m_ovf[b]);
      m_unf[b]   = s_unf   ? 1'b1 : (clr ? 1'b0 : m_unf[b]);
      m_proto[b] = s_proto ? 1'b1 : (clr ? 1'b0 : m_proto[b]);
      if (idle && vld[b] && wr[b]) m_busy[b] = PB;
      else if (m_busy[b] > 0) m_busy[b]--;
      if (inc && en && m_stat[b] < (2**SW - 1)) m_stat[b]++;
    end
    m_any = any_prev;
  endtask

  task automatic check_all();
    for (int b = 0; b < NB; b++) begin
      chk($sformatf("iq_cnt[%0d]", b), 32'(iq_cnt[b*CW +: CW]), 32'(m_cnt[b]));
      chk($sformatf("ovf_err[%0d]", b), 32'(ovf_err[b]), 32'(m_ovf[b]));
      chk($sformatf("unf_err[%0d]", b), 32'(unf_err[b]), 32'(m_unf[b]));
      chk($sformatf("proto_err[%0d]", b), 32'(proto_err[b]), 32'(m_proto[b]));
`ifdef SII_L2T_TRACKER_STATS_EN
      chk($sformatf("req_stat[%0d]", b), 32'(req_stat[b*SW +: SW]), 32'(m_stat[b]));
`endif
    end
    chk("err_any", 32'(err_any), 32'(m_any));
  endtask

  // One transaction: drive, clock, update model, compare, log.
  task automatic step(input logic [NB-1:0] v, input logic [NB-1:0] w,
                      input logic [NB-1:0] d, input logic e, input logic c);
    vld = v; wr = w; deq = d; en = e; clr = c;
    for (int b = 0; b < NB; b++) begin
      req[b*RW +: RW] = $urandom;
      req[b*RW + WRB] = w[b];
    end
    @(posedge clk);
    model_update();
    #1;
    step_no++;
    check_all();
    $display("step %0d vld=%02h wr=%02h deq=%02h en=%0b clr=%0b", step_no, v, w, d, e, c);
  endtask

  // Asynchronous reset asserted between edges, checked before any edge.
  task automatic do_reset();
    vld = '0; wr = '0; deq = '0; clr = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("rst_async_cnt4", 32'(iq_cnt[4*CW +: CW]), 32'd0);
    $display("reset asserted at %0t", $time);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = '0; vld = '0; deq = '0; wr = '0; en = 1'b1; clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("reset_err_any", 32'(err_any), 32'd0);
    rst = 1'b0;

    // Bank 3: 16 reads fill the queue, the 17th overflows.
    for (int i = 0; i < 16; i++) step(8'h08, 8'h00, 8'h00, 1'b1, 1'b0);
    chk("b3_full", 32'(iq_cnt[3*CW +: CW]), 32'd16);
    step(8'h08, 8'h00, 8'h00, 1'b1, 1'b0);
    chk("b3_cnt_hold", 32'(iq_cnt[3*CW +: CW]), 32'd16);
    chk("b3_ovf", 32'(ovf_err), 32'h08);
    chk("b3_err_any_lag", 32'(err_any), 32'd0);
    step(8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    chk("b3_err_any", 32'(err_any), 32'd1);
    do_reset();

    // Bank 0: inc+dec cancel at 5, then drain and underflow.
    for (int i = 0; i < 5; i++) step(8'h01, 8'h00, 8'h00, 1'b1, 1'b0);
    step(8'h01, 8'h00, 8'h01, 1'b1, 1'b0);
    chk("b0_incdec", 32'(iq_cnt[0 +: CW]), 32'd5);
    for (int i = 0; i < 5; i++) step(8'h00, 8'h00, 8'h01, 1'b1, 1'b0);
    step(8'h00, 8'h00, 8'h01, 1'b1, 1'b0);
    chk("b0_unf", 32'(unf_err), 32'h01);
    chk("b0_cnt_zero", 32'(iq_cnt[0 +: CW]), 32'd0);
    do_reset();

    // Bank 5: header during payload beat 2, then next legal header.
    step(8'h20, 8'h20, 8'h00, 1'b1, 1'b0);
    step(8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    step(8'h20, 8'h00, 8'h00, 1'b1, 1'b0);
    chk("b5_proto", 32'(proto_err), 32'h20);
    chk("b5_cnt1", 32'(iq_cnt[5*CW +: CW]), 32'd1);
    step(8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    step(8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    step(8'h20, 8'h00, 8'h00, 1'b1, 1'b0);
    chk("b5_cnt2", 32'(iq_cnt[5*CW +: CW]), 32'd2);
    do_reset();

    // All banks write together; a read on every bank 5 cycles later.
    step(8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    step(8'hFF, 8'h00, 8'h00, 1'b1, 1'b0);
    chk("all_cnt7", 32'(iq_cnt[7*CW +: CW]), 32'd2);
    chk("all_no_proto", 32'(proto_err), 32'd0);
    do_reset();

    // Bank 1: overflow with enable low, then clr_err racing a new set.
    for (int i = 0; i < 17; i++) step(8'h02, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("b1_sat", 32'(iq_cnt[1*CW +: CW]), 32'd16);
    chk("b1_no_flag", 32'(ovf_err), 32'd0);
    step(8'h02, 8'h00, 8'h00, 1'b1, 1'b1);
    chk("b1_set_wins", 32'(ovf_err), 32'h02);
    step(8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
    chk("b1_cleared", 32'(ovf_err), 32'd0);
    do_reset();

`ifdef SII_L2T_TRACKER_STATS_EN
    // Bank 2: 20 headers saturate a 4-bit stat counter.
    for (int i = 0; i < 20; i++) step(8'h04, 8'h00, 8'h04, 1'b1, 1'b0);
    chk("b2_stat_sat", 32'(req_stat[2*SW +: SW]), 32'd15);
    do_reset();
`endif

    // Reset mid-write; first cycle afterwards is idle.
    step(8'h10, 8'h10, 8'h00, 1'b1, 1'b0);
    step(8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    do_reset();
    step(8'h10, 8'h00, 8'h00, 1'b1, 1'b0);
    chk("b4_post_rst", 32'(iq_cnt[4*CW +: CW]), 32'd1);
    chk("b4_no_proto", 32'(proto_err), 32'd0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      step(NB'($urandom & $urandom), NB'($urandom), NB'($urandom & $urandom),
           ($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
